// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a transmit FIFO.
// Per-frame data length (5..8, or 9 when DATA_BITS=9), one or two stop bits and
// optional parity, all sampled when a character is popped from the FIFO.
// Build option: define UART_TX_PARITY_EN to enable the PARITY state and par_mode;
// without it par_mode is ignored and DATA is followed directly by STOP.

module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          PRESETn,
  input  logic                          tx_en,
  input  logic                          s_tick,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic [1:0]                    data_len,
  input  logic                          stop2,
  input  logic [1:0]                    par_mode,
  input  logic                          err_clr,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Number of data bits for a data_len code, clamped to the storage width.
  function automatic logic [NW-1:0] frame_bits(input logic [1:0] len);
    logic [NW-1:0] n;
    n = NW'(len) + NW'(5);
    if (len == 2'b11 && DATA_BITS == 9) n = NW'(9);
    if (n > NW'(DATA_BITS)) n = NW'(DATA_BITS);
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level_nxt;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 push_ok;
  logic                 push_drop;

  assign head = mem[rd_ptr];

  // Push acceptance and next occupancy; a pop frees the slot a full push needs.
  always_comb begin
    push_ok   = wr_en && (!fifo_full || pop);
    push_drop = wr_en && fifo_full && !pop;
    level_nxt = fifo_level;
    if (push_ok && !pop)      level_nxt = fifo_level + LW'(1);
    else if (pop && !push_ok) level_nxt = fifo_level - LW'(1);
  end

  // Storage array; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_nxt;
      fifo_empty <= (level_nxt == '0);
      fifo_full  <= (level_nxt == LW'(FIFO_DEPTH));
      if (push_drop)    ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [NW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [NW-1:0]        lat_nbits;
  logic                 lat_stop2;
  logic [NW-1:0]        pop_nbits;
  logic                 bit_end;
  logic                 last_stop;
  logic                 stop_end;

  assign pop_nbits = frame_bits(data_len);

`ifdef UART_TX_PARITY_EN
  logic lat_par_en;
  logic lat_par_bit;
  logic par_en_nxt;
  logic par_calc;

  // Parity over the bits of the character about to be popped.
  always_comb begin
    par_en_nxt = (par_mode == 2'b01) || (par_mode == 2'b10);
    par_calc   = 1'b0;
    for (int i = 0; i < int'(DATA_BITS); i++) begin
      if (i < int'(pop_nbits)) par_calc = par_calc ^ head[i];
    end
    if (par_mode == 2'b10) par_calc = ~par_calc;
  end

  // Parity configuration captured with the character.
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      lat_par_en  <= 1'b0;
      lat_par_bit <= 1'b0;
    end else if (pop) begin
      lat_par_en  <= par_en_nxt;
      lat_par_bit <= par_calc;
    end
  end
`else
  logic unused_par_mode;
  assign unused_par_mode = ^par_mode;
`endif

  // Bit-boundary and pop decisions shared by the FIFO and the sequencer.
  always_comb begin
    bit_end   = s_tick && (state != IDLE) && (tick_cnt == TW'(OVERSAMPLE - 1));
    last_stop = (bit_cnt == NW'(lat_stop2));
    stop_end  = (state == STOP) && bit_end && last_stop;
    pop       = tx_en && !fifo_empty && ((state == IDLE) || stop_end);
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      lat_nbits <= '0;
      lat_stop2 <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_en) begin
        state    <= IDLE;
        tx       <= 1'b1;
        tx_busy  <= 1'b0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (pop) begin
        if (state == STOP) tx_done <= 1'b1;
        state     <= START;
        tx        <= 1'b0;
        tx_busy   <= 1'b1;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        shreg     <= head;
        lat_nbits <= pop_nbits;
        lat_stop2 <= stop2;
      end else if (state != IDLE) begin
        if (s_tick) tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
        if (bit_end) begin
          case (state)
            START: begin
              state   <= DATA;
              tx      <= shreg[0];
              bit_cnt <= '0;
            end
            DATA: begin
              if (bit_cnt == lat_nbits - NW'(1)) begin
`ifdef UART_TX_PARITY_EN
                if (lat_par_en) begin
                  state <= PARITY;
                  tx    <= lat_par_bit;
                end else begin
                  state   <= STOP;
                  tx      <= 1'b1;
                  bit_cnt <= '0;
                end
`else
                state   <= STOP;
                tx      <= 1'b1;
                bit_cnt <= '0;
`endif
              end else begin
                bit_cnt <= bit_cnt + NW'(1);
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_cnt <= '0;
            end
`endif
            STOP: begin
              if (last_stop) begin
                tx_done <= 1'b1;
                state   <= IDLE;
                tx      <= 1'b1;
                tx_busy <= 1'b0;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + NW'(1);
              end
            end
            default: begin
              state   <= IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: table-driven frames, FIFO/overflow sequences,
// enable-drop and reset-abort sequences, and randomized batches checked
// against a tick-level frame model. Follows UART_TX_PARITY_EN if defined.

module tb_uart_tx_cfg;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;
  localparam int unsigned FD = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          PRESETn = 1'b0;
  logic          tx_en = 1'b0;
  logic          s_tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic [1:0]    data_len = 2'b11;
  logic          stop2 = 1'b0;
  logic [1:0]    par_mode = 2'b00;
  logic          err_clr = 1'b0;
  logic          tx, tx_busy, tx_done, fifo_full, fifo_empty, ovf_err;
  logic [2:0]    fifo_level;

  uart_tx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .PRESETn(PRESETn), .tx_en(tx_en), .s_tick(s_tick),
    .wr_en(wr_en), .wr_data(wr_data), .data_len(data_len), .stop2(stop2),
    .par_mode(par_mode), .err_clr(err_clr), .tx(tx), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic obs_q[$];
  logic exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  len;
    logic        s2;
    logic [1:0]  pm;
    int          nlev;
    logic [15:0] levels;
  } vec_t;
  vec_t vt[6];

  // Oversample strobe: random density, changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tick = ($urandom_range(0, 2) != 0);
    end
  end

  // Line level at every strobe during a frame, plus tx_done pulse count.
  always @(negedge clk) begin
    if (PRESETn) begin
      if (s_tick && tx_busy) obs_q.push_back(tx);
      if (tx_done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic add_level(input logic v);
    repeat (OS) exp_q.push_back(v);
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  task automatic add_frame(input logic [7:0] d, input logic [1:0] len,
                           input logic s2, input logic [1:0] pm);
    int   nb;
    int   plev;
    logic p;
    nb = int'(len) + 5;
    p  = 1'b0;
    add_level(1'b0);
    for (int i = 0; i < nb; i++) begin
      add_level(d[i]);
      p = p ^ d[i];
    end
    plev = -1;
    if (pm == 2'b01) plev = int'(p);
    else if (pm == 2'b10) plev = int'(!p);
    if (PAR_BUILD && plev >= 0) add_level(plev != 0);
    add_level(1'b1);
    if (s2) add_level(1'b1);
  endtask

  task automatic cmp_trace(input string name, input int base);
    int got;
    int diff;
    got  = obs_q.size() - base;
    diff = exp_q.size();
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      if (obs_q[base + i] !== exp_q[i]) begin
        diff = i;
        break;
      end
    end
    chk({name, "_ticks"}, got, exp_q.size());
    chk({name, "_first_bad_tick"}, diff, exp_q.size());
  endtask

  task automatic wait_done(input int n, input int done0, input int budget, input string name);
    int c;
    c = 0;
    while ((done_cnt - done0) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if ((done_cnt - done0) < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d tx_done expected %0d", name, done_cnt - done0, n);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"}, int'(tx), 1);
    chk({tag, "_busy"}, int'(tx_busy), 0);
    chk({tag, "_done"}, int'(tx_done), 0);
    chk({tag, "_ovf"}, int'(ovf_err), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_empty"}, int'(fifo_empty), 1);
    chk({tag, "_full"}, int'(fifo_full), 0);
  endtask

  initial begin
    int base;
    int done0;
    int gaps;
    int got;
    int c;
    bit seen;
    logic [1:0] rl;
    logic       rs;
    logic [1:0] rp;
    logic [7:0] d;
    int nb;

    // Levels listed first-sent in bit 0.
    vt[0] = '{8'h55, 2'b11, 1'b0, 2'b00, 10, 16'h02AA};
    vt[1] = '{8'hFF, 2'b00, 1'b1, 2'b00, 8, 16'h00FE};
`ifdef UART_TX_PARITY_EN
    vt[2] = '{8'h07, 2'b11, 1'b0, 2'b01, 11, 16'h060E};
    vt[3] = '{8'h07, 2'b11, 1'b0, 2'b10, 11, 16'h040E};
    vt[5] = '{8'h3C, 2'b01, 1'b0, 2'b10, 9, 16'h01F8};
`else
    vt[2] = '{8'h07, 2'b11, 1'b0, 2'b01, 10, 16'h020E};
    vt[3] = '{8'h07, 2'b11, 1'b0, 2'b10, 10, 16'h020E};
    vt[5] = '{8'h3C, 2'b01, 1'b0, 2'b10, 8, 16'h00F8};
`endif
    vt[4] = '{8'hA3, 2'b10, 1'b0, 2'b00, 9, 16'h0146};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    PRESETn = 1'b1;
    step();

    // Table-driven frames; config scrambled mid-frame must not matter.
    tx_en = 1'b1;
    foreach (vt[v]) begin
      data_len = vt[v].len;
      stop2    = vt[v].s2;
      par_mode = vt[v].pm;
      exp_q.delete();
      for (int i = 0; i < vt[v].nlev; i++) add_level(vt[v].levels[i]);
      base  = obs_q.size();
      done0 = done_cnt;
      push(vt[v].data);
      repeat (40) step();
      data_len = 2'($urandom);
      stop2    = 1'($urandom);
      par_mode = 2'($urandom);
      wait_done(1, done0, 3000, $sformatf("vec%0d", v));
      repeat (4) step();
      chk($sformatf("vec%0d_done_pulses", v), done_cnt - done0, 1);
      cmp_trace($sformatf("vec%0d", v), base);
    end

    // FIFO fill while disabled, overflow and err_clr priority.
    tx_en    = 1'b0;
    data_len = 2'b11;
    stop2    = 1'b0;
    par_mode = 2'b00;
    step();
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    chk("fill3_full", int'(fifo_full), 0);
    chk("fill3_level", int'(fifo_level), 3);
    push(8'h44);
    @(negedge clk);
    chk("fill4_full", int'(fifo_full), 1);
    chk("fill4_level", int'(fifo_level), 4);
    chk("fill4_ovf", int'(ovf_err), 0);
    push(8'h55);
    @(negedge clk);
    chk("drop_ovf", int'(ovf_err), 1);
    chk("drop_level", int'(fifo_level), 4);
    err_clr = 1'b1;
    push(8'h66);
    err_clr = 1'b0;
    @(negedge clk);
    chk("drop_with_clr_ovf", int'(ovf_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_ovf", int'(ovf_err), 0);
    push(8'h77);
    @(negedge clk);
    chk("redrop_ovf", int'(ovf_err), 1);

    // Drain four frames back to back.
    exp_q.delete();
    add_frame(8'h11, 2'b11, 1'b0, 2'b00);
    add_frame(8'h22, 2'b11, 1'b0, 2'b00);
    add_frame(8'h33, 2'b11, 1'b0, 2'b00);
    add_frame(8'h44, 2'b11, 1'b0, 2'b00);
    base  = obs_q.size();
    done0 = done_cnt;
    tx_en = 1'b1;
    gaps = 0; got = 0; c = 0; seen = 1'b0;
    while (got < 4 && c < 4000) begin
      @(negedge clk);
      c++;
      if (tx_done) got++;
      if (tx_busy) seen = 1'b1;
      else if (seen && got < 4) gaps++;
    end
    repeat (4) step();
    chk("drain_done_pulses", done_cnt - done0, 4);
    chk("drain_idle_gaps", gaps, 0);
    cmp_trace("drain", base);
    chk("drain_empty", int'(fifo_empty), 1);

    // Enable dropped during data bit 3.
    tx_en = 1'b0;
    step();
    push(8'h55);
    push(8'hA5);
    base  = obs_q.size();
    done0 = done_cnt;
    tx_en = 1'b1;
    c = 0;
    while ((obs_q.size() - base) < int'(4 * OS + 4) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reached_bit3", int'((obs_q.size() - base) >= int'(4 * OS + 4)), 1);
    chk("abort_tx_before", int'(tx), 0);
    tx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_level", int'(fifo_level), 1);
    repeat (60) step();
    chk("abort_no_done", done_cnt - done0, 0);

    // Reset pulse in the middle of the next frame.
    base  = obs_q.size();
    tx_en = 1'b1;
    c = 0;
    while ((obs_q.size() - base) < 40 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    push(8'h3C);
    @(negedge clk);
    chk("pre_reset_busy", int'(tx_busy), 1);
    @(posedge clk);
    #3;
    PRESETn = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    PRESETn = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_reset_busy", int'(tx_busy), 0);

    // Randomized batches, one configuration per batch.
    for (int b = 0; b < 6; b++) begin
      rl = 2'($urandom);
      rs = 1'($urandom);
      rp = 2'($urandom);
      data_len = rl;
      stop2    = rs;
      par_mode = rp;
      exp_q.delete();
      base  = obs_q.size();
      done0 = done_cnt;
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        d = 8'($urandom);
        add_frame(d, rl, rs, rp);
        push(d);
        repeat ($urandom_range(0, 30)) step();
      end
      wait_done(nb, done0, 3000, $sformatf("rnd%0d", b));
      repeat (4) step();
      chk($sformatf("rnd%0d_done_pulses", b), done_cnt - done0, nb);
      cmp_trace($sformatf("rnd%0d", b), base);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, max frame data width (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, s_tick pulses per bit period (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_en  input  1  transmitter enable.
REQ-007 SHALL have port s_tick  input  1  one-clk baud-oversample strobe.
REQ-008 SHALL have port wr_en  input  1  FIFO push strobe.
REQ-009 SHALL have port wr_data  input  DATA_BITS  character to push.
REQ-010 SHALL have port data_len  input  2  data bits per frame minus 5 (00=5 .. 11=8); 9 bits when DATA_BITS=9 and data_len=11.
REQ-011 SHALL have port stop2  input  1  0=one stop bit, 1=two stop bits.
REQ-012 SHALL have port par_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-013 SHALL have port err_clr  input  1  clears ovf_err.
REQ-014 SHALL have port tx  output  1  serial line, idle high.
REQ-015 SHALL have ports tx_busy (output 1, frame in progress) and tx_done (output 1, one-clk end-of-frame pulse).
REQ-016 SHALL have ports fifo_full, fifo_empty (output 1 each) and fifo_level (output $clog2(FIFO_DEPTH)+1, entry count).
REQ-017 SHALL have port ovf_err  output  1  sticky push-while-full flag.

Function
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP; tx_busy=1 in every state except IDLE.
REQ-019 SHALL pop the FIFO head and go IDLE->START when tx_en=1 and fifo_empty=0; tx=0 from that same edge.
REQ-020 SHALL latch data_len, stop2, par_mode at the pop; changes mid-frame do not affect the current frame.
REQ-021 SHALL hold each bit for exactly OVERSAMPLE s_tick pulses, counted by a tick counter cleared on every bit boundary.
REQ-022 SHALL send data LSB first, then parity (if enabled), then 1 or 2 stop bits (tx=1); the STOP phase lasts OVERSAMPLE or 2*OVERSAMPLE ticks.
REQ-023 SHALL compute parity over the latched data_len bits only: even = XOR, odd = ~XOR.
REQ-024 SHALL pulse tx_done for one clk on the edge ending STOP, then go to START (pop) if tx_en=1 and FIFO non-empty, else IDLE; there is no idle gap between back-to-back frames.
REQ-025 SHALL, on a push with FIFO not full, store wr_data and increment fifo_level; a simultaneous push and pop leaves fifo_level unchanged.
REQ-026 SHALL drop a push while full unless a pop occurs the same cycle; a dropped push sets ovf_err.
REQ-027 SHALL clear ovf_err on err_clr=1; a simultaneous dropped push and err_clr leaves ovf_err=1.
REQ-028 SHALL, when tx_en=0 in any state, return to IDLE with tx=1 at the next edge, discard the in-flight frame without a tx_done pulse, and retain FIFO contents; pushes remain accepted.
REQ-029 SHALL ignore s_tick in IDLE; an s_tick coinciding with the pop does not count toward START.

Reset
REQ-030 SHALL asynchronously, on PRESETn=0, force tx=1, tx_busy=0, tx_done=0, ovf_err=0, fifo_level=0, fifo_empty=1, fifo_full=0, state IDLE, all counters and pointers 0.
REQ-031 SHALL, on reset mid-frame, abort the frame and empty the FIFO; operation resumes on the first edge after release.

Configuration
REQ-032 SHALL support macro UART_TX_PARITY_EN: when defined, the PARITY state and par_mode are functional per REQ-023.
REQ-033 SHALL, when UART_TX_PARITY_EN is undefined, contain no parity logic, ignore par_mode, and send DATA directly to STOP.

Verification
REQ-034 SHALL cover: OVERSAMPLE=16, 8N1, push 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level 16 ticks, one tx_done pulse.
REQ-035 SHALL cover: macro defined, par_mode=01, data_len=11, push 0x07 -> parity bit 1; par_mode=10 -> parity bit 0.
REQ-036 SHALL cover: data_len=00, stop2=1, push 0xFF -> 5 data ones, then 32 ticks high before tx_done.
REQ-037 SHALL cover: FIFO_DEPTH=4, 5 pushes while tx_en=0 -> fifo_full=1 after the 4th, ovf_err=1, then tx_en=1 -> 4 back-to-back frames, 4 tx_done pulses.
REQ-038 SHALL cover: tx_en dropped at data bit 3 -> tx=1 next edge, no tx_done, fifo_level unchanged; PRESETn pulse mid-frame -> all REQ-030 values.
